// File: rtl/i2c_frame_responder.sv
// I2C read-frame target: shifts {HEADER, sensor byte, HEADER^sensor}
// MSB-first onto open-drain SDA, one bit per SCL low phase.
module i2c_frame_responder #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         SETUP_DLY   = 2,
  parameter int         RELEASE_DLY = 12,
  parameter int         TIMEOUT     = 255
) (
  input  logic       clk_1MHz,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] sensor_data,
  input  logic       data_valid,
  output logic       busy,
  output logic       frame_sent,
  output logic       frame_err
);

  typedef enum logic [2:0] {IDLE, ARMED, DRIVE, HOLD, TAIL} state_t;

  localparam logic [3:0] SETUP_M1 = 4'(SETUP_DLY - 1);
  localparam logic [3:0] REL_M1   = 4'(RELEASE_DLY - 1);
  localparam logic [7:0] TMO_M1   = 8'(TIMEOUT - 1);

  state_t      state;
  logic        scl_s1, scl_s2, scl_p;
  logic        sda_s1, sda_s2, sda_p;
  logic [7:0]  hold;
  logic [23:0] shadow;
  logic [4:0]  bit_idx;
  logic [3:0]  dly;
  logic [7:0]  tmo;
  logic        sda_low;

  logic scl_rise, scl_fall, scl_edge, start_c, stop_c;

  assign sda      = sda_low ? 1'b0 : 1'bz;
  assign busy     = (state != IDLE);
  assign scl_rise = scl_s2 & ~scl_p;
  assign scl_fall = ~scl_s2 & scl_p;
  assign scl_edge = scl_rise | scl_fall;
  assign start_c  = scl_s2 & sda_p & ~sda_s2;
  assign stop_c   = scl_s2 & ~sda_p & sda_s2;

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_p  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_p  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_p  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_p  <= sda_s2;
    end
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst)             hold <= 8'h00;
    else if (data_valid) hold <= sensor_data;
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= 24'h0;
      bit_idx    <= 5'd0;
      dly        <= 4'd0;
      tmo        <= 8'd0;
      sda_low    <= 1'b0;
      frame_sent <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_sent <= 1'b0;
      frame_err  <= 1'b0;
      if (start_c) begin
        // hold is read before this cycle's data_valid update lands
        shadow  <= {HEADER, hold, HEADER ^ hold};
        bit_idx <= 5'd0;
        tmo     <= 8'd0;
        sda_low <= 1'b0;
        state   <= ARMED;
      end else if (state == IDLE) begin
        sda_low <= 1'b0;
      end else if (stop_c || (tmo == TMO_M1 && !scl_edge)) begin
        sda_low   <= 1'b0;
        frame_err <= 1'b1;
        state     <= IDLE;
      end else begin
        tmo <= scl_edge ? 8'd0 : tmo + 8'd1;
        case (state)
          ARMED: begin
            if (scl_fall) begin
              dly   <= 4'd0;
              state <= DRIVE;
            end
          end
          DRIVE: begin
            if (dly == SETUP_M1) begin
              sda_low <= ~shadow[5'd23 - bit_idx];
              state   <= HOLD;
            end else begin
              dly <= dly + 4'd1;
            end
          end
          HOLD: begin
            if (scl_fall && bit_idx != 5'd23) begin
              bit_idx <= bit_idx + 5'd1;
              dly     <= 4'd0;
              state   <= DRIVE;
            end else if (scl_rise && bit_idx == 5'd23) begin
              dly   <= 4'd0;
              state <= TAIL;
            end
          end
          TAIL: begin
            if (scl_fall || (scl_s2 && dly == REL_M1)) begin
              sda_low    <= 1'b0;
              frame_sent <= 1'b1;
              state      <= IDLE;
            end else if (scl_s2) begin
              dly <= dly + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_frame_responder.md
Name: i2c_frame_responder

Overview:
Target/slave end of the 3-byte I2C read frame {Header, Sensor Data, Checksum}. The frame is clocked out by the on-chip or remote I2C frame-read master at 1 MHz system clock with 10 µs SCL half-periods. No address phase and no ACK.
- Detects START on the bus.
- Shifts 24 bits MSB-first onto open-drain SDA, changing SDA only while SCL is low.
- Releases the bus after the last bit.
- Sensor data is captured from a local strobe; the checksum is generated internally.

Parameters:
HEADER, 8'hA5, constant header byte (frame bits 23:16)
SETUP_DLY, 2, clk cycles after detected SCL fall before the next bit is presented on SDA (range 1..7)
RELEASE_DLY, 12, clk cycles of SCL high after the 24th rising edge before SDA is released (must exceed master high time of 10)
TIMEOUT, 255, max clk cycles without any SCL edge while busy before abort (8-bit counter)

Ports:
clk_1MHz  input  1  system clock, 1 MHz
rst  input  1  asynchronous reset, active-high
scl  input  1  I2C clock from master
sda  inout  1  I2C data, open-drain: driven 0 or z only
sensor_data  input  8  new sensor byte
data_valid  input  1  1-cycle strobe; latches sensor_data into hold register
busy  output  1  high while a frame is in progress (state != IDLE)
frame_sent  output  1  1-cycle pulse when a full 24-bit frame completes
frame_err  output  1  1-cycle pulse on abort (STOP mid-frame or timeout)

Behaviour:
- Reset (async, rst=1):
  - SDA released (z); busy=0, frame_sent=0, frame_err=0.
  - Hold register = 0, shadow frame = 0, bit_idx = 0, state = IDLE.
  - Reset mid-frame releases SDA in the same instant, with no clock needed.
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer plus a previous-value register.
  - Edges are therefore seen 3 cycles after the pin change.
  - START = sync SDA 1→0 while sync SCL=1.
  - STOP = sync SDA 0→1 while sync SCL=1.
- Hold register: any cycle with data_valid=1 loads sensor_data, busy or not.
- Shadow load: on START, shadow = {HEADER, hold, HEADER ^ hold}. The shadow is never modified during a frame.
- SDA drive: pull low when the current bit = 0; z when the bit = 1 or in any non-driving state.
- FSM:
  - IDLE: SDA z. START → ARMED; load shadow; bit_idx=0; clear timeout counter. STOP is ignored.
  - ARMED: waits for the first SCL fall. On the fall → DRIVE.
  - DRIVE: counts SETUP_DLY cycles, then presents shadow[23-bit_idx] → HOLD.
  - HOLD: bit stays stable through SCL rise and the whole high phase.
    - SCL fall with bit_idx<23 → bit_idx+1, go to DRIVE.
    - SCL rise with bit_idx=23 → TAIL.
  - TAIL: keeps the last bit until sync SCL has been high for RELEASE_DLY cycles. Then releases SDA, pulses frame_sent, → IDLE.
    - An SCL fall in TAIL also releases SDA, pulses frame_sent, → IDLE.
- Abort conditions (any non-IDLE state):
  - STOP → release SDA, pulse frame_err, → IDLE.
  - No SCL edge for TIMEOUT cycles → same as STOP.
  - The timeout counter clears on every SCL edge.
  - STOP seen in TAIL after release is normal (IDLE ignores it).
- Repeated START in any non-IDLE state: reload shadow from the current hold register, bit_idx=0, → ARMED, no frame_err.
- Simultaneous data_valid and START in the same cycle: the shadow uses the old hold value; the new value goes to the next frame.
- Checksum width: 8-bit bitwise XOR, no carry.
- The block never drives SDA while SCL is sync-high except to hold an already-presented bit.

Test Plan:
- data_valid with sensor_data=0x3C, then full master read frame → master frame_data=0xA53C99; frame_sent pulses once; busy falls in the same cycle; SDA z afterwards.
- After reset with no data_valid, read frame → 0xA500A5.
- data_valid with 0xFF after START mid-frame (frame loaded with 0x3C) → current frame 0xA53C99; next frame 0xA5FF5A.
- STOP (SDA rise, SCL high) after 10 bits → frame_err pulse; SDA z within 4 cycles; no frame_sent; next START works normally.
- SCL held low 300 cycles mid-frame → frame_err at 255 cycles without an edge; busy=0; SDA z.
- rst asserted while driving a 0 bit → SDA z immediately; busy=0. After deassert, a full read returns {HEADER, 0x00, HEADER}.
